// File: rtl/iex_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// iex_muldiv_pkg
// Shared definitions for the execute-stage iterative multiply/divide unit:
//   md_op_e        M-extension sub-op encodings driven on iex_muldiv.op
//   md_state_e     control FSM state encoding
//   md_cnt_width   width of the iteration counter (must be able to hold XLEN)
// -----------------------------------------------------------------------------
package iex_muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MUL   = 2'b00,
        MD_MULHU = 2'b01,
        MD_DIVU  = 2'b10,
        MD_REMU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } md_state_e;

    function automatic int unsigned md_cnt_width(input int unsigned xlen);
        return unsigned'($clog2(xlen)) + 1;
    endfunction

endpackage

// File: rtl/iex_muldiv.sv
// -----------------------------------------------------------------------------
// iex_muldiv
// Iterative unsigned multiply / divide unit sitting behind the ID/EX register.
// One iteration per clock, XLEN iterations per operation; busy stalls the
// front of the pipe, done is a one-cycle pulse with result held afterwards.
//
// Ports
//   clk      in   pipeline clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   request from EX (already qualified as a mul/div, non-bubble)
//   flush    in   hazard-unit clear; aborts any operation in flight
//   op       in   00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   srca     in   multiplicand / dividend
//   srcb     in   multiplier / divisor
//   busy     out  high while iterating
//   done     out  one-cycle completion pulse
//   result   out  last completed result, held until the next completion
// -----------------------------------------------------------------------------
module iex_muldiv
    import iex_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned     CNT_W     = md_cnt_width(XLEN);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    md_state_e        state_q, state_d;
    md_op_e           op_q, op_d;
    logic [XLEN-1:0]  opnd_q, opnd_d;   // srca for multiply, srcb (divisor) for divide
    logic [XLEN-1:0]  hi_q, hi_d;       // product high word / partial remainder
    logic [XLEN-1:0]  lo_q, lo_d;       // product low word + multiplier / dividend + quotient
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic             accept;
    logic             op_is_div;
    logic             div_by_zero;
    logic             run_is_div;
    logic [XLEN:0]    mul_sum;
    logic [XLEN:0]    div_shift;
    logic [XLEN:0]    div_diff;

    assign accept      = start && !flush;
    assign op_is_div   = op[1];
    assign div_by_zero = op_is_div && (srcb == '0);
    assign run_is_div  = (op_q == MD_DIVU) || (op_q == MD_REMU);

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = div_by_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // --------------------------------------------------- outputs and datapath
    // Multiply and divide share the hi/lo pair. The partial remainder is stored
    // XLEN bits wide; only the shifted value needs the extra bit for the sign
    // of the trial subtraction, since a restored remainder is always < divisor.
    always_comb begin
        op_d     = op_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        busy_d   = (state_d == RUN);

        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d  = md_op_e'(op);
                    cnt_d = '0;
                    if (op_is_div) begin
                        opnd_d = srcb;
                        if (div_by_zero) begin
                            // Preload the RISC-V divide-by-zero answers so DONE
                            // selects them exactly like a normal completion.
                            hi_d = srca;
                            lo_d = '1;
                        end else begin
                            hi_d = '0;
                            lo_d = srca;
                        end
                    end else begin
                        opnd_d = srca;
                        hi_d   = '0;
                        lo_d   = srcb;
                    end
                end
            end
            RUN: begin
                if (!flush) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (run_is_div) begin
                        if (!div_diff[XLEN]) begin
                            hi_d = div_diff[XLEN-1:0];
                            lo_d = {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            hi_d = div_shift[XLEN-1:0];
                            lo_d = {lo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        hi_d = mul_sum[XLEN:1];
                        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                end
            end
            DONE: begin
                if (!flush) begin
                    done_d = 1'b1;
                    case (op_q)
                        MD_MUL:   result_d = lo_q;
                        MD_MULHU: result_d = hi_q;
                        MD_DIVU:  result_d = lo_q;
                        MD_REMU:  result_d = hi_q;
                        default:  result_d = lo_q;
                    endcase
                end
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= MD_MUL;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_iex_muldiv.sv
module tb_iex_muldiv;
    import iex_muldiv_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    iex_muldiv #(.XLEN(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .flush   (flush),
        .op      (op),
        .srca    (srca),
        .srcb    (srcb),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation and watch 60 negedge samples after the accepting edge.
    // Sample k=1 is the first negedge after acceptance. Operands are scrambled
    // right after acceptance. If inj_k > 0 a second start is pulsed at sample inj_k.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inj_k, output logic [31:0] res, output int busy_n,
                          output int done_k, output int overlap, output int dbl);
        busy_n = 0; done_k = 0; overlap = 0; dbl = 0; res = '0;
        @(negedge clk);
        start = 1'b1; op = o; srca = a; srcb = b;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                op = ~o; srca = 32'hDEAD_BEEF; srcb = 32'h0000_0003;
            end
            if (inj_k == k) begin
                start = 1'b1; op = MD_MUL; srca = 32'd2; srcb = 32'd2;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_n++;
            if (busy && done) overlap++;
            if (done) begin
                if (done_k == 0) begin
                    done_k = k;
                    res = result;
                end else begin
                    dbl++;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; srca = '0; srcb = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 00000000", result); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        logic [31:0] r; int bn, dk, ov, db;
        run_op(MD_MUL, 32'd7, 32'd6, 0, r, bn, dk, ov, db);
        checks++; if (r !== 32'd42) begin errors++; $display("FAIL mul_7x6 got %h exp %h", r, 32'd42); end
        checks++; if (bn !== 32) begin errors++; $display("FAIL mul_busy_cycles got %0d exp 32", bn); end
        checks++; if (dk !== 34) begin errors++; $display("FAIL mul_latency got %0d exp 34", dk); end
        checks++; if (ov !== 0) begin errors++; $display("FAIL mul_busy_done_overlap got %0d exp 0", ov); end
        checks++; if (db !== 0) begin errors++; $display("FAIL mul_done_repeat got %0d exp 0", db); end
        checks++; if (result !== 32'd42) begin errors++; $display("FAIL mul_result_held got %h exp %h", result, 32'd42); end
    endtask

    task automatic test_mulhu();
        logic [31:0] r; int bn, dk, ov, db;
        run_op(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r, bn, dk, ov, db);
        checks++; if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_max got %h exp FFFFFFFE", r); end
        checks++; if (dk !== 34) begin errors++; $display("FAIL mulhu_latency got %0d exp 34", dk); end
        run_op(MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r, bn, dk, ov, db);
        checks++; if (r !== 32'h0000_0001) begin errors++; $display("FAIL mul_max_lo got %h exp 00000001", r); end
    endtask

    task automatic test_div();
        logic [31:0] r; int bn, dk, ov, db;
        run_op(MD_DIVU, 32'd100, 32'd7, 0, r, bn, dk, ov, db);
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu_100_7 got %h exp %h", r, 32'd14); end
        checks++; if (bn !== 32) begin errors++; $display("FAIL divu_busy_cycles got %0d exp 32", bn); end
        checks++; if (dk !== 34) begin errors++; $display("FAIL divu_latency got %0d exp 34", dk); end
        run_op(MD_REMU, 32'd100, 32'd7, 0, r, bn, dk, ov, db);
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu_100_7 got %h exp %h", r, 32'd2); end
        run_op(MD_DIVU, 32'hFFFF_FFFF, 32'd1, 0, r, bn, dk, ov, db);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_max_1 got %h exp FFFFFFFF", r); end
        run_op(MD_REMU, 32'hFFFF_FFFF, 32'h1000_0000, 0, r, bn, dk, ov, db);
        checks++; if (r !== 32'h0FFF_FFFF) begin errors++; $display("FAIL remu_max got %h exp 0FFFFFFF", r); end
    endtask

    task automatic test_div_zero();
        logic [31:0] r; int bn, dk, ov, db;
        run_op(MD_DIVU, 32'h0000_1234, 32'h0, 0, r, bn, dk, ov, db);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero got %h exp FFFFFFFF", r); end
        checks++; if (dk !== 2) begin errors++; $display("FAIL divu_zero_latency got %0d exp 2", dk); end
        checks++; if (bn !== 0) begin errors++; $display("FAIL divu_zero_busy got %0d exp 0", bn); end
        checks++; if (db !== 0) begin errors++; $display("FAIL divu_zero_repeat got %0d exp 0", db); end
        run_op(MD_REMU, 32'h0000_1234, 32'h0, 0, r, bn, dk, ov, db);
        checks++; if (r !== 32'h0000_1234) begin errors++; $display("FAIL remu_zero got %h exp 00001234", r); end
        checks++; if (dk !== 2) begin errors++; $display("FAIL remu_zero_latency got %0d exp 2", dk); end
    endtask

    task automatic test_flush();
        logic [31:0] r; int bn, dk, ov, db, seen_done, seen_busy;
        // result currently holds 0x1234 from the REMU-by-zero case
        @(negedge clk);
        start = 1'b1; op = MD_MUL; srca = 32'd3; srcb = 32'd5;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", busy); end
        seen_done = 0; seen_busy = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) seen_done++;
            if (busy) seen_busy++;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL flush_no_done got %0d exp 0", seen_done); end
        checks++; if (seen_busy !== 0) begin errors++; $display("FAIL flush_stays_idle got %0d exp 0", seen_busy); end
        checks++; if (result !== 32'h0000_1234) begin errors++; $display("FAIL flush_result_kept got %h exp 00001234", result); end

        run_op(MD_MUL, 32'd3, 32'd5, 0, r, bn, dk, ov, db);
        checks++; if (r !== 32'd15) begin errors++; $display("FAIL post_flush_mul got %h exp %h", r, 32'd15); end
        checks++; if (dk !== 34) begin errors++; $display("FAIL post_flush_latency got %0d exp 34", dk); end

        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = MD_MUL; srca = 32'd9; srcb = 32'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy got %b exp 0", busy); end
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL flush_start_no_done got %0d exp 0", seen_done); end
        checks++; if (result !== 32'd15) begin errors++; $display("FAIL flush_start_result got %h exp %h", result, 32'd15); end
    endtask

    task automatic test_second_start();
        logic [31:0] r; int bn, dk, ov, db;
        run_op(MD_DIVU, 32'd100, 32'd7, 5, r, bn, dk, ov, db);
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL ignored_start_result got %h exp %h", r, 32'd14); end
        checks++; if (dk !== 34) begin errors++; $display("FAIL ignored_start_latency got %0d exp 34", dk); end
        checks++; if (db !== 0) begin errors++; $display("FAIL ignored_start_extra_done got %0d exp 0", db); end
    endtask

    task automatic test_reset_mid_run();
        // result holds 14 here, so clearing it to zero is observable
        @(negedge clk);
        start = 1'b1; op = MD_MUL; srca = 32'd11; srcb = 32'd13;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b exp 1", busy); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL async_reset_done got %b exp 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL async_reset_result got %h exp 00000000", result); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL post_reset_no_partial got %h exp 00000000", result); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulhu();
        test_div();
        test_div_zero();
        test_flush();
        test_second_start();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/iex_muldiv.md
Name: iex_muldiv

Overview:
Iterative unsigned multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register. It consumes the EX-stage operands and an M-extension sub-op. It raises busy so the hazard unit stalls IF/ID/EX while it runs. When finished it presents a one-cycle done pulse with a held result for the EX/MEM register.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  pipeline clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  EX-stage request; qualified by ID/EX control (mul/div op, not a bubble).
flush  input  1  hazard-unit clear (same condition that clears ID/EX); aborts the operation in flight.
op  input  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU.
srca  input  XLEN  multiplicand / dividend.
srcb  input  XLEN  multiplier / divisor.
busy  output  1  registered; high during iteration; drives the stall.
done  output  1  registered; one-cycle pulse when result is valid.
result  output  XLEN  registered; holds its last value until the next completion.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; busy=0, done=0, result=0.
  - counter, product/remainder and quotient registers cleared.
  - Applies equally mid-operation; no partial result survives.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and flush=0: latch op, srca, srcb; counter=0.
  - DIVU/REMU with srcb==0: go to DONE directly. Result is all-ones (DIVU) or srca (REMU), per RISC-V.
  - Otherwise go to RUN with busy=1.
- RUN: one iteration per clock; counter increments; after XLEN iterations go to DONE and busy falls.
  - Multiply: 2*XLEN accumulator {hi,lo}, lo initialised to srcb. Each step: if lo[0], hi+=srca with the carry kept in an XLEN+1 add; then shift the whole accumulator right by 1.
  - Divide: restoring. Remainder (XLEN+1 bits) shifts left, taking the dividend MSB. Subtract the divisor; if non-negative keep the difference and set quotient bit=1, else restore and set bit=0.
- DONE (one cycle):
  - done=1; result = lo (MUL), hi (MULHU), quotient (DIVU) or remainder (REMU).
  - Next state is IDLE. done is never high for two consecutive cycles.
- Latency:
  - start sampled at edge T gives done=1 in the cycle after edge T+XLEN+1 (33 edges for XLEN=32).
  - Divide-by-zero gives done in the cycle after edge T+1.
- start while busy or in DONE is ignored; no queueing. The pipeline is stalled, so start holds for the same instruction.
- flush in RUN or DONE: go to IDLE next edge. busy=0 and done=0; result unchanged; no done pulse.
- flush and start together in IDLE: flush wins; nothing is accepted.
- Operand inputs may change after acceptance without effect; only the latched copies are used.
- All arithmetic is unsigned, modulo 2^XLEN on the result; no overflow flag.

Decomposition:
- Shared package holds:
  - op encodings (MD_MUL=2'b00, MD_MULHU=2'b01, MD_DIVU=2'b10, MD_REMU=2'b11);
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - counter width = clog2(XLEN)+1.
- No sub-module. The datapath is one shared accumulator register set; a separate step module adds hierarchy without reuse.

Test Plan:
- MUL 7×6: start with srca=7, srcb=6 → busy high for 32 cycles, then done pulse with result=42; busy and done never high together.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → result=0xFFFFFFFE. A following MUL on the same operands → result=0x00000001.
- DIVU 100/7 → 14; REMU 100/7 → 2. DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.
- DIVU x/0 with srca=0x1234 → done the cycle after acceptance, result=0xFFFFFFFF, busy never asserted. REMU x/0 → result=0x1234.
- Flush at iteration 10 of a MUL → busy=0 next cycle, no done pulse, result keeps the prior value. A new start then completes correctly. Flush and start in the same IDLE cycle → nothing accepted.
- reset_n pulled low mid-RUN, asynchronously between edges → busy, done and result go to 0 immediately. A second start pulse asserted while busy is ignored, and the first operation's result is returned.
